// File: rtl/pipe_mem_arbiter.sv
// Shares one memory port between NUM_PORTS requesters, one transaction at a time.
// Arbitration is fixed-priority (MODE 0) or round-robin (MODE 1); all memory-side outputs are registered.
module pipe_mem_arbiter #(
   parameter int NUM_PORTS  = 2,
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 16,
   parameter int MODE       = 0
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic [NUM_PORTS-1:0]                   req_read,
   input  logic [NUM_PORTS-1:0]                   req_write,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0]        req_addr,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0]        req_wdata,
   input  logic [NUM_PORTS*(DATA_WIDTH/8)-1:0]    req_wmask,
   output logic [NUM_PORTS-1:0]                   req_resp,
   output logic [DATA_WIDTH-1:0]                  req_rdata,
   output logic [NUM_PORTS-1:0]                   req_stall,
   output logic [$clog2(NUM_PORTS)-1:0]           grant_id,
   output logic                                   busy,
   output logic                                   mem_read,
   output logic                                   mem_write,
   output logic [ADDR_WIDTH-1:0]                  mem_address,
   output logic [DATA_WIDTH-1:0]                  mem_wdata,
   output logic [DATA_WIDTH/8-1:0]                mem_byte_enable,
   input  logic [DATA_WIDTH-1:0]                  mem_rdata,
   input  logic                                   mem_resp
);
   localparam int GW = $clog2(NUM_PORTS);
   localparam int BW = DATA_WIDTH / 8;

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t                r_state;
   logic [GW-1:0]         r_last;

   logic [NUM_PORTS-1:0]  w_req;
   logic                  w_any;
   logic [GW-1:0]         w_win;
   logic [GW-1:0]         w_cand;
   int                    w_idx;
   logic                  w_sel_wr;
   logic                  w_sel_rd;
   logic [ADDR_WIDTH-1:0] w_sel_addr;
   logic [DATA_WIDTH-1:0] w_sel_wdata;
   logic [BW-1:0]         w_sel_mask;

   assign w_req     = req_read | req_write;
   assign w_any     = |w_req;
   assign req_stall = w_req & ~req_resp;

   // Walk the search order backwards so the earliest requesting candidate is the last one written.
   always_comb begin
      w_win  = '0;
      w_cand = '0;
      w_idx  = 0;
      for (int k = NUM_PORTS - 1; k >= 0; k--) begin
         w_idx = (MODE == 1) ? int'(r_last) + 1 + k : k;
         if (w_idx >= NUM_PORTS) begin
            w_idx = w_idx - NUM_PORTS;
         end
         w_cand = GW'(w_idx);
         if (w_req[w_cand]) begin
            w_win = w_cand;
         end
      end
   end

   // A port raising read and write together is served as a write.
   always_comb begin
      w_sel_wr    = req_write[w_win];
      w_sel_rd    = req_read[w_win] & ~req_write[w_win];
      w_sel_addr  = req_addr[int'(w_win)*ADDR_WIDTH +: ADDR_WIDTH];
      w_sel_wdata = req_wdata[int'(w_win)*DATA_WIDTH +: DATA_WIDTH];
      w_sel_mask  = req_wmask[int'(w_win)*BW +: BW];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state         <= S_IDLE;
         r_last          <= GW'(NUM_PORTS - 1);
         grant_id        <= '0;
         busy            <= 1'b0;
         mem_read        <= 1'b0;
         mem_write       <= 1'b0;
         mem_address     <= '0;
         mem_wdata       <= '0;
         mem_byte_enable <= '0;
         req_resp        <= '0;
         req_rdata       <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_state         <= S_BUSY;
                  r_last          <= w_win;
                  grant_id        <= w_win;
                  busy            <= 1'b1;
                  mem_read        <= w_sel_rd;
                  mem_write       <= w_sel_wr;
                  mem_address     <= w_sel_addr;
                  mem_wdata       <= w_sel_wdata;
                  mem_byte_enable <= w_sel_mask;
               end
            end
            S_BUSY: begin
               if (mem_resp) begin
                  r_state   <= S_DONE;
                  mem_read  <= 1'b0;
                  mem_write <= 1'b0;
                  req_rdata <= mem_rdata;
                  req_resp  <= NUM_PORTS'(1) << grant_id;
               end
            end
            S_DONE: begin
               r_state  <= S_IDLE;
               req_resp <= '0;
               busy     <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// Drives a 2-port fixed-priority and a 4-port round-robin arbiter from a shared memory responder
// and compares every phase of each transaction against a transaction-level reference model.
module tb_pipe_mem_arbiter;
   logic        clk;
   logic        rst_n;
   logic        mem_resp;
   logic [15:0] mem_rdata;

   logic [1:0]  fp_rd, fp_wr, fp_resp, fp_stall, fp_mbe;
   logic [31:0] fp_addr, fp_wdata;
   logic [3:0]  fp_mask;
   logic [15:0] fp_rdata, fp_maddr, fp_mwd;
   logic [0:0]  fp_gid;
   logic        fp_busy, fp_mrd, fp_mwr;

   logic [3:0]  rr_rd, rr_wr, rr_resp, rr_stall;
   logic [63:0] rr_addr, rr_wdata;
   logic [7:0]  rr_mask;
   logic [15:0] rr_rdata, rr_maddr, rr_mwd;
   logic [1:0]  rr_gid, rr_mbe;
   logic        rr_busy, rr_mrd, rr_mwr;

   pipe_mem_arbiter #(.NUM_PORTS(2), .ADDR_WIDTH(16), .DATA_WIDTH(16), .MODE(0)) u_fp (
      .clk(clk), .rst_n(rst_n), .req_read(fp_rd), .req_write(fp_wr), .req_addr(fp_addr),
      .req_wdata(fp_wdata), .req_wmask(fp_mask), .req_resp(fp_resp), .req_rdata(fp_rdata),
      .req_stall(fp_stall), .grant_id(fp_gid), .busy(fp_busy), .mem_read(fp_mrd),
      .mem_write(fp_mwr), .mem_address(fp_maddr), .mem_wdata(fp_mwd),
      .mem_byte_enable(fp_mbe), .mem_rdata(mem_rdata), .mem_resp(mem_resp));

   pipe_mem_arbiter #(.NUM_PORTS(4), .ADDR_WIDTH(16), .DATA_WIDTH(16), .MODE(1)) u_rr (
      .clk(clk), .rst_n(rst_n), .req_read(rr_rd), .req_write(rr_wr), .req_addr(rr_addr),
      .req_wdata(rr_wdata), .req_wmask(rr_mask), .req_resp(rr_resp), .req_rdata(rr_rdata),
      .req_stall(rr_stall), .grant_id(rr_gid), .busy(rr_busy), .mem_read(rr_mrd),
      .mem_write(rr_mwr), .mem_address(rr_maddr), .mem_wdata(rr_mwd),
      .mem_byte_enable(rr_mbe), .mem_rdata(mem_rdata), .mem_resp(mem_resp));

   // Both DUTs viewed through one indexable set of outputs: 0 = fixed priority, 1 = round-robin.
   logic [3:0]  o_resp [2];
   logic [3:0]  o_stall[2];
   logic [1:0]  o_gid  [2];
   logic [1:0]  o_mbe  [2];
   logic        o_busy [2];
   logic        o_mrd  [2];
   logic        o_mwr  [2];
   logic [15:0] o_maddr[2];
   logic [15:0] o_mwd  [2];
   logic [15:0] o_rdata[2];

   assign o_resp[0]  = {2'b00, fp_resp};   assign o_resp[1]  = rr_resp;
   assign o_stall[0] = {2'b00, fp_stall};  assign o_stall[1] = rr_stall;
   assign o_gid[0]   = {1'b0, fp_gid};     assign o_gid[1]   = rr_gid;
   assign o_mbe[0]   = fp_mbe;             assign o_mbe[1]   = rr_mbe;
   assign o_busy[0]  = fp_busy;            assign o_busy[1]  = rr_busy;
   assign o_mrd[0]   = fp_mrd;             assign o_mrd[1]   = rr_mrd;
   assign o_mwr[0]   = fp_mwr;             assign o_mwr[1]   = rr_mwr;
   assign o_maddr[0] = fp_maddr;           assign o_maddr[1] = rr_maddr;
   assign o_mwd[0]   = fp_mwd;             assign o_mwd[1]   = rr_mwd;
   assign o_rdata[0] = fp_rdata;           assign o_rdata[1] = rr_rdata;

   // Reference model: outstanding request per port, last granted port, last returned read data.
   logic        p_rd   [2][4];
   logic        p_wr   [2][4];
   logic [15:0] p_addr [2][4];
   logic [15:0] p_wdata[2][4];
   logic [1:0]  p_mask [2][4];
   int          last   [2];
   logic [15:0] exp_rdata[2];
   int          g_obs  [2];

   int checks   = 0;
   int failures = 0;
   int ord [5]  = '{0, 1, 2, 3, 0};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int nports(input int d);
      return (d == 0) ? 2 : 4;
   endfunction

   // First pending port in search order: lowest index for fixed priority,
   // otherwise starting just after the last granted port and wrapping.
   function automatic int pick(input int d);
      int n     = nports(d);
      int start = (d == 0) ? 0 : (last[d] + 1) % n;
      for (int k = 0; k < n; k++) begin
         int i = (start + k) % n;
         if (p_rd[d][i] || p_wr[d][i]) return i;
      end
      return -1;
   endfunction

   function automatic logic [3:0] bus_req(input int d);
      if (d == 0) return {2'b00, fp_rd | fp_wr};
      return rr_rd | rr_wr;
   endfunction

   task automatic drive(input int d);
      if (d == 0) begin
         for (int i = 0; i < 2; i++) begin
            fp_rd[i] = p_rd[0][i];  fp_wr[i] = p_wr[0][i];
            fp_addr[i*16 +: 16] = p_addr[0][i];  fp_wdata[i*16 +: 16] = p_wdata[0][i];
            fp_mask[i*2 +: 2] = p_mask[0][i];
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            rr_rd[i] = p_rd[1][i];  rr_wr[i] = p_wr[1][i];
            rr_addr[i*16 +: 16] = p_addr[1][i];  rr_wdata[i*16 +: 16] = p_wdata[1][i];
            rr_mask[i*2 +: 2] = p_mask[1][i];
         end
      end
   endtask

   task automatic set_req(input int d, input int i, input logic rd, input logic wr,
                          input logic [15:0] a, input logic [15:0] wd, input logic [1:0] m);
      p_rd[d][i] = rd;  p_wr[d][i] = wr;
      p_addr[d][i] = a;  p_wdata[d][i] = wd;  p_mask[d][i] = m;
   endtask

   task automatic new_req(input int d, input int i);
      int op = $urandom_range(0, 2);
      set_req(d, i, op != 1, op != 0, 16'($urandom), 16'($urandom), 2'($urandom));
   endtask

   task automatic refill(input int d, input int pct);
      for (int i = 0; i < nports(d); i++) begin
         if (!(p_rd[d][i] || p_wr[d][i]) && $urandom_range(0, 99) < pct) new_req(d, i);
      end
      drive(d);
   endtask

   // Other ports come and go while the granted port's bus fields are disturbed.
   task automatic noise(input int d, input int w);
      for (int i = 0; i < nports(d); i++) begin
         if (i != w) begin
            if (p_rd[d][i] || p_wr[d][i]) begin
               if ($urandom_range(0, 3) == 0) begin p_rd[d][i] = 1'b0; p_wr[d][i] = 1'b0; end
            end else if ($urandom_range(0, 3) == 0) begin
               new_req(d, i);
            end
         end
      end
      drive(d);
      if ($urandom_range(0, 1) == 1) begin
         if (d == 0) begin
            fp_addr[w*16 +: 16] = 16'($urandom);  fp_wdata[w*16 +: 16] = 16'($urandom);
            fp_mask[w*2 +: 2] = 2'($urandom);
         end else begin
            rr_addr[w*16 +: 16] = 16'($urandom);  rr_wdata[w*16 +: 16] = 16'($urandom);
            rr_mask[w*2 +: 2] = 2'($urandom);
         end
      end
   endtask

   task automatic check_busy(input int d, input bit act, input int w, input logic wr,
                             input logic [15:0] a, input logic [15:0] wd, input logic [1:0] m,
                             input string tag);
      chk($sformatf("%s_d%0d_busy", tag, d), o_busy[d], act);
      chk($sformatf("%s_d%0d_resp", tag, d), o_resp[d], 0);
      chk($sformatf("%s_d%0d_stall", tag, d), o_stall[d], bus_req(d));
      if (act) begin
         chk($sformatf("%s_d%0d_strobe", tag, d), {o_mrd[d], o_mwr[d]}, wr ? 2'b01 : 2'b10);
         chk($sformatf("%s_d%0d_gid", tag, d), o_gid[d], 64'(w));
         chk($sformatf("%s_d%0d_addr", tag, d), o_maddr[d], a);
         chk($sformatf("%s_d%0d_wdata", tag, d), o_mwd[d], wd);
         chk($sformatf("%s_d%0d_mask", tag, d), o_mbe[d], m);
      end else begin
         chk($sformatf("%s_d%0d_strobe", tag, d), {o_mrd[d], o_mwr[d]}, 2'b00);
      end
   endtask

   // One arbitration round for both DUTs; starts and ends one step after an edge with the DUTs idle.
   task automatic do_txn(input int dly, input bit nz, input logic [15:0] rd);
      int          w  [2];
      bit          act[2];
      logic        ewr[2];
      logic [15:0] ea [2];
      logic [15:0] ewd[2];
      logic [1:0]  em [2];
      for (int d = 0; d < 2; d++) begin
         w[d] = pick(d);
         act[d] = (w[d] >= 0);
         ewr[d] = 1'b0;  ea[d] = '0;  ewd[d] = '0;  em[d] = '0;
         if (act[d]) begin
            ewr[d] = p_wr[d][w[d]];  ea[d] = p_addr[d][w[d]];
            ewd[d] = p_wdata[d][w[d]];  em[d] = p_mask[d][w[d]];
         end
      end
      @(posedge clk); #1;
      mem_resp  = (dly == 0);
      mem_rdata = mem_resp ? rd : 16'($urandom);
      for (int d = 0; d < 2; d++) begin
         check_busy(d, act[d], w[d], ewr[d], ea[d], ewd[d], em[d], "grant");
         g_obs[d] = int'(o_gid[d]);
      end
      for (int c = 0; c < dly; c++) begin
         if (nz) begin
            for (int d = 0; d < 2; d++) if (act[d]) noise(d, w[d]);
         end
         @(posedge clk); #1;
         mem_resp  = (c == dly - 1);
         mem_rdata = mem_resp ? rd : 16'($urandom);
         for (int d = 0; d < 2; d++) check_busy(d, act[d], w[d], ewr[d], ea[d], ewd[d], em[d], "hold");
      end
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
         logic [3:0] er;
         er = act[d] ? (4'b0001 << w[d]) : 4'b0000;
         if (act[d]) exp_rdata[d] = rd;
         chk($sformatf("done_d%0d_resp", d), o_resp[d], er);
         chk($sformatf("done_d%0d_busy", d), o_busy[d], act[d]);
         chk($sformatf("done_d%0d_strobe", d), {o_mrd[d], o_mwr[d]}, 2'b00);
         chk($sformatf("done_d%0d_rdata", d), o_rdata[d], exp_rdata[d]);
         chk($sformatf("done_d%0d_stall", d), o_stall[d], bus_req(d) & ~er);
      end
      mem_resp  = 1'($urandom_range(0, 1));
      mem_rdata = 16'($urandom);
      for (int d = 0; d < 2; d++) begin
         if (act[d]) begin
            p_rd[d][w[d]] = 1'b0;  p_wr[d][w[d]] = 1'b0;  last[d] = w[d];
         end
         drive(d);
      end
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("idle_d%0d_resp", d), o_resp[d], 0);
         chk($sformatf("idle_d%0d_busy", d), o_busy[d], 0);
         chk($sformatf("idle_d%0d_strobe", d), {o_mrd[d], o_mwr[d]}, 2'b00);
         chk($sformatf("idle_d%0d_rdata", d), o_rdata[d], exp_rdata[d]);
      end
      mem_resp = 1'($urandom_range(0, 1));
   endtask

   task automatic chk_regs_zero(input string tag);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("%s_d%0d", tag, d),
             {o_busy[d], o_mrd[d], o_mwr[d], o_resp[d], o_gid[d], o_maddr[d], o_mwd[d],
              o_mbe[d], o_rdata[d]}, 64'd0);
      end
   endtask

   initial begin
      rst_n = 1'b0;  mem_resp = 1'b0;  mem_rdata = '0;
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 4; i++) set_req(d, i, 1'b0, 1'b0, '0, '0, '0);
         last[d] = nports(d) - 1;  exp_rdata[d] = '0;  g_obs[d] = 0;
         drive(d);
      end
      #12;
      chk_regs_zero("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;

      // No requests: stays idle and ignores stray mem_resp.
      repeat (3) begin
         mem_resp = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         chk_regs_zero("idle_noreq");
      end
      mem_resp = 1'b0;

      // Ports 0 and 1 read together.
      for (int d = 0; d < 2; d++) begin
         set_req(d, 0, 1'b1, 1'b0, 16'h0010, 16'h0000, 2'b11);
         set_req(d, 1, 1'b1, 1'b0, 16'h0020, 16'h0000, 2'b11);
         drive(d);
      end
      do_txn(2, 1'b0, 16'hA5A5);
      chk("fp_pair_first", g_obs[0], 0);
      do_txn(1, 1'b0, 16'h5A5A);
      chk("fp_pair_second", g_obs[0], 1);

      // Masked write from port 1.
      for (int d = 0; d < 2; d++) begin
         set_req(d, 1, 1'b0, 1'b1, 16'h0040, 16'hBEEF, 2'b10);
         drive(d);
      end
      do_txn(3, 1'b0, 16'h0BAD);
      chk("wr_beef_gid", g_obs[0], 1);

      // Read with slow memory.
      for (int d = 0; d < 2; d++) begin
         set_req(d, 0, 1'b1, 1'b0, 16'h0100, 16'h0000, 2'b11);
         drive(d);
      end
      do_txn(5, 1'b0, 16'h1234);
      chk("slow_rd_rdata", o_rdata[0], 16'h1234);

      // Read and write together on one port.
      for (int d = 0; d < 2; d++) begin
         set_req(d, 0, 1'b1, 1'b1, 16'h0200, 16'hC0DE, 2'b01);
         drive(d);
      end
      do_txn(1, 1'b0, 16'h7777);

      // Reset in the middle of a transaction.
      for (int d = 0; d < 2; d++) refill(d, 100);
      @(posedge clk); #1;
      mem_resp = 1'b0;
      chk("rst_mid_busy_fp", o_busy[0], 1);
      chk("rst_mid_busy_rr", o_busy[1], 1);
      #2 rst_n = 1'b0;
      #1 chk_regs_zero("rst_async");
      @(posedge clk); #1;
      chk_regs_zero("rst_held");
      rst_n = 1'b1;
      for (int d = 0; d < 2; d++) begin
         last[d] = nports(d) - 1;  exp_rdata[d] = '0;
      end

      // Every port requesting continuously.
      for (int k = 0; k < 5; k++) begin
         for (int d = 0; d < 2; d++) refill(d, 100);
         do_txn(0, 1'b0, 16'($urandom));
         chk($sformatf("rr_order_%0d", k), g_obs[1], ord[k]);
         chk($sformatf("fp_order_%0d", k), g_obs[0], 0);
      end

      // Random traffic.
      repeat (60) begin
         refill(0, 50);
         refill(1, 50);
         if (pick(0) < 0 && pick(1) < 0) begin
            new_req(1, $urandom_range(0, 3));
            drive(1);
         end
         do_txn($urandom_range(0, 4), 1'b1, 16'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
